// File: rtl/lsu_riscv_if.sv
// Core-side and memory-side signal bundle of the load/store unit.
// master = the LSU itself, slave = the environment (core pipeline + data memory).
interface lsu_riscv_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport master (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o, err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );

  modport slave (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o, err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/lsu_riscv.sv
// RISC-V load/store unit: one data-memory transaction per load/store, stalls the core until done.
// Define MISALIGN_TRAP_EN to trap misaligned H/HU/W accesses instead of issuing them truncated.
module lsu_riscv #(
  parameter int MEM_TIMEOUT = 255
) (
  input logic         clk_i,
  input logic         rst_i,
  lsu_riscv_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  size_t       size_q, size_d;
  logic        uns_q, uns_d;
  logic        we_q, we_d;
  logic [1:0]  off_q, off_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;
  logic        stall;

  // Request decode: size class, byte enables and lane-replicated store data.
  size_t       req_size;
  logic        req_uns;
  logic [1:0]  req_off;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic        misalign;

  assign req_off = bus.core_addr_i[1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    req_size = SZ_W;
    req_uns  = 1'b0;
    case (bus.core_size_i)
      3'd0: req_size = SZ_B;
      3'd1: req_size = SZ_H;
      3'd4: begin req_size = SZ_B; req_uns = 1'b1; end
      3'd5: begin req_size = SZ_H; req_uns = 1'b1; end
      default: req_size = SZ_W;
    endcase

    req_be = 4'b1111;
    req_wd = bus.core_wd_i;
    case (req_size)
      SZ_B: begin
        req_be = 4'b0001 << req_off;
        req_wd = {4{bus.core_wd_i[7:0]}};
      end
      SZ_H: begin
        req_be = 4'b0011 << {req_off[1], 1'b0};
        req_wd = {2{bus.core_wd_i[15:0]}};
      end
      default: ;
    endcase
    if (!bus.core_we_i) req_wd = '0;
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_size == SZ_H) && req_off[0]) || ((req_size == SZ_W) && (req_off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Load extraction uses the offset latched at issue, not the live address.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ld_byte = bus.mem_rd_i[{off_q, 3'b000} +: 8];
  assign ld_half = bus.mem_rd_i[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      SZ_B:    ld_data = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = bus.mem_rd_i;
    endcase
  end

  logic timeout;
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    uns_d      = uns_q;
    we_d       = we_q;
    off_d      = off_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_be_d   = mem_be_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    rd_d       = rd_q;
    err_d      = 1'b0;
    stall      = 1'b0;

    case (state_q)
      IDLE: begin
        stall = bus.core_req_i;
        if (bus.core_req_i) begin
          size_d = req_size;
          uns_d  = req_uns;
          we_d   = bus.core_we_i;
          off_d  = req_off;
          cnt_d  = '0;
          if (misalign) begin
            rd_d    = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = bus.core_we_i;
            mem_be_d   = req_be;
            mem_addr_d = {bus.core_addr_i[31:2], 2'b00};
            mem_wd_d   = req_wd;
            state_d    = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        // Ready has priority over a timeout landing in the same cycle.
        if (bus.mem_ready_i) begin
          if (!we_q) rd_d = ld_data;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else if (timeout) begin
          rd_d      = '0;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      size_q     <= SZ_W;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      off_q      <= 2'b00;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= 4'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      we_q       <= we_d;
      off_q      <= off_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_be_q   <= mem_be_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
    end
  end

  assign bus.core_rd_o    = rd_q;
  assign bus.core_stall_o = stall;
  assign bus.err_o        = err_q;
  assign bus.mem_req_o    = mem_req_q;
  assign bus.mem_we_o     = mem_we_q;
  assign bus.mem_be_o     = mem_be_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wd_o     = mem_wd_q;

endmodule

// File: tb/tb_lsu_riscv.sv
// Directed self-checking bench for lsu_riscv (built with MEM_TIMEOUT=4 so the timeout is reachable).
// Misaligned-access expectations follow MISALIGN_TRAP_EN when it is defined for the build.
module tb_lsu_riscv;

  localparam int BOUND = 40;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  lsu_riscv_if bus();

  lsu_riscv #(.MEM_TIMEOUT(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations collected over one transaction.
  int          stall_cnt, req_cnt, err_cnt, cyc;
  logic [3:0]  be1;
  logic [31:0] addr1, wd1;
  logic        we1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request and run it until the stall drops; ready is given in BUSY cycle ready_at (0 = never).
  task automatic txn(input string name, input logic we, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                     input int ready_at);
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = we;
    bus.core_size_i = size;
    bus.core_addr_i = addr;
    bus.core_wd_i   = wd;
    bus.mem_rd_i    = rd;
    bus.mem_ready_i = 1'b0;
    stall_cnt = 0; req_cnt = 0; err_cnt = 0; cyc = 0;
    be1 = 'x; addr1 = 'x; wd1 = 'x; we1 = 'x;
    #1;
    while (bus.core_stall_o && cyc < BOUND) begin
      stall_cnt++;
      if (bus.mem_req_o) req_cnt++;
      if (cyc == 1) begin
        be1 = bus.mem_be_o; addr1 = bus.mem_addr_o; wd1 = bus.mem_wd_o; we1 = bus.mem_we_o;
      end
      bus.mem_ready_i = (ready_at != 0) && (cyc == ready_at);
      tick();
      cyc++;
      if (bus.err_o) err_cnt++;
    end
    check({name, ".bounded"}, 32'(cyc < BOUND), 32'd1);
  endtask

  // Leave the DONE cycle with the request still high, then confirm no reissue and no lingering error.
  task automatic retire(input string name);
    tick();
    bus.core_req_i  = 1'b0;
    bus.mem_ready_i = 1'b0;
    #1;
    check({name, ".idle_req"},   32'(bus.mem_req_o),    32'd0);
    check({name, ".idle_err"},   32'(bus.err_o),        32'd0);
    check({name, ".idle_stall"}, 32'(bus.core_stall_o), 32'd0);
  endtask

  initial begin
    bus.core_req_i  = 1'b0;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = 3'd0;
    bus.core_addr_i = '0;
    bus.core_wd_i   = '0;
    bus.mem_rd_i    = '0;
    bus.mem_ready_i = 1'b0;

    tick();
    tick();
    check("rst.req",   32'(bus.mem_req_o),    32'd0);
    check("rst.we",    32'(bus.mem_we_o),     32'd0);
    check("rst.be",    32'(bus.mem_be_o),     32'd0);
    check("rst.addr",  bus.mem_addr_o,        32'd0);
    check("rst.wd",    bus.mem_wd_o,          32'd0);
    check("rst.rd",    bus.core_rd_o,         32'd0);
    check("rst.err",   32'(bus.err_o),        32'd0);
    check("rst.stall", 32'(bus.core_stall_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Load B, sign-extended from byte lane 2.
    txn("ldb", 1'b0, 3'd0, 32'h0000_0202, 32'hFFFF_FFFF, 32'h0080_0000, 1);
    check("ldb.stall", stall_cnt, 2);
    check("ldb.be",    32'(be1),  32'h4);
    check("ldb.addr",  addr1,     32'h0000_0200);
    check("ldb.wd",    wd1,       32'h0);
    check("ldb.we",    32'(we1),  32'd0);
    check("ldb.rd",    bus.core_rd_o, 32'hFFFF_FF80);
    check("ldb.err",   err_cnt,   0);
    retire("ldb");

    // Store B in the top lane; load result must survive.
    txn("stb", 1'b1, 3'd0, 32'h0000_0103, 32'h1234_56AB, 32'h5555_5555, 1);
    check("stb.stall", stall_cnt, 2);
    check("stb.be",    32'(be1),  32'h8);
    check("stb.addr",  addr1,     32'h0000_0100);
    check("stb.wd",    wd1,       32'hABAB_ABAB);
    check("stb.we",    32'(we1),  32'd1);
    check("stb.rd",    bus.core_rd_o, 32'hFFFF_FF80);
    retire("stb");

    txn("ldbu", 1'b0, 3'd4, 32'h0000_0202, 32'h0, 32'h0080_0000, 1);
    check("ldbu.rd", bus.core_rd_o, 32'h0000_0080);
    retire("ldbu");

    txn("ldhu", 1'b0, 3'd5, 32'h0000_0206, 32'h0, 32'hBEEF_1234, 1);
    check("ldhu.be", 32'(be1),       32'hC);
    check("ldhu.rd", bus.core_rd_o,  32'h0000_BEEF);
    retire("ldhu");

    txn("sth", 1'b1, 3'd1, 32'h0000_0206, 32'h1111_CAFE, 32'h0, 1);
    check("sth.be", 32'(be1), 32'hC);
    check("sth.wd", wd1,      32'hCAFE_CAFE);
    retire("sth");

    // Illegal size 3 behaves as a word store.
    txn("stw3", 1'b1, 3'd3, 32'h0000_010C, 32'hCAFE_F00D, 32'h0, 1);
    check("stw3.be",   32'(be1), 32'hF);
    check("stw3.wd",   wd1,      32'hCAFE_F00D);
    check("stw3.addr", addr1,    32'h0000_010C);
    retire("stw3");

    // Ready arrives in the same BUSY cycle the timeout would fire: ready wins.
    txn("ldw", 1'b0, 3'd2, 32'h0000_0208, 32'h0, 32'hDEAD_BEEF, 4);
    check("ldw.stall", stall_cnt,     5);
    check("ldw.rd",    bus.core_rd_o, 32'hDEAD_BEEF);
    check("ldw.err",   err_cnt,       0);
    retire("ldw");

    txn("tmo", 1'b0, 3'd2, 32'h0000_0300, 32'h0, 32'h1234_5678, 0);
    check("tmo.req",   req_cnt,       4);
    check("tmo.stall", stall_cnt,     5);
    check("tmo.err",   err_cnt,       1);
    check("tmo.rd",    bus.core_rd_o, 32'h0);
    retire("tmo");

    txn("mis", 1'b0, 3'd2, 32'h0000_0102, 32'h0, 32'h0BAD_F00D, 1);
`ifdef MISALIGN_TRAP_EN
    check("mis.stall", stall_cnt,     1);
    check("mis.req",   req_cnt,       0);
    check("mis.err",   err_cnt,       1);
    check("mis.rd",    bus.core_rd_o, 32'h0);
`else
    check("mis.stall", stall_cnt,     2);
    check("mis.be",    32'(be1),      32'hF);
    check("mis.addr",  addr1,         32'h0000_0100);
    check("mis.err",   err_cnt,       0);
    check("mis.rd",    bus.core_rd_o, 32'h0BAD_F00D);
`endif
    retire("mis");

    txn("ldh", 1'b0, 3'd1, 32'h0000_0204, 32'h0, 32'h0000_8001, 1);
    check("ldh.rd", bus.core_rd_o, 32'hFFFF_8001);
    retire("ldh");

    // Reset in the second BUSY cycle abandons the load.
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = 3'd2;
    bus.core_addr_i = 32'h0000_0300;
    bus.mem_rd_i    = 32'h7777_7777;
    bus.mem_ready_i = 1'b0;
    tick();
    check("mid.busy_req", 32'(bus.mem_req_o), 32'd1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check("mid.req",   32'(bus.mem_req_o),    32'd0);
    check("mid.stall", 32'(bus.core_stall_o), 32'd1);
    check("mid.err",   32'(bus.err_o),        32'd0);
    check("mid.rd",    bus.core_rd_o,         32'h0);
    bus.core_req_i = 1'b0;
    #1;
    check("mid.stall_low", 32'(bus.core_stall_o), 32'd0);
    tick();
    check("mid.idle_req", 32'(bus.mem_req_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_riscv.md
Name: lsu_riscv

Overview:
- Load/store unit directly downstream of the ALU: takes the ALU result as the effective address and runs one data-memory transaction per load/store.
- Generates byte enables and replicates store data across byte lanes.
- Extracts and sign/zero-extends load data.
- Stalls the core until the memory responds or a timeout fires. Sits between the execute stage and the data-memory port.

Parameters:
- MEM_TIMEOUT, 255, max cycles in BUSY waiting for mem_ready_i before abort; 0 disables the timeout.

Ports:
- clk_i  input  1  clock; everything samples on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- core_req_i  input  1  load/store request; held stable by the core while core_stall_o=1.
- core_we_i  input  1  1=store, 0=load.
- core_size_i  input  3  funct3 encoding: 0=B, 1=H, 2=W, 4=BU, 5=HU; others illegal.
- core_addr_i  input  32  effective address (ALU result).
- core_wd_i  input  32  store data (rs2).
- core_rd_o  output  32  extended load data, registered.
- core_stall_o  output  1  core must hold the current instruction.
- err_o  output  1  one-cycle pulse: timeout, or misaligned access when MISALIGN_TRAP_EN is defined.
- mem_req_o  output  1  memory request, registered.
- mem_we_o  output  1  memory write enable, registered.
- mem_be_o  output  4  byte enables, registered.
- mem_addr_o  output  32  {addr[31:2],2'b00}, registered.
- mem_wd_o  output  32  lane-replicated store data, registered.
- mem_rd_i  input  32  memory read data, valid with mem_ready_i.
- mem_ready_i  input  1  memory completes the transaction this cycle.

Behaviour:
- Reset:
  - state=IDLE; timeout counter=0.
  - All registered outputs = 0.
  - Reset asserted mid-transaction abandons it: mem_req_o=0 the next cycle, no core_rd_o update, no err_o.
- Illegal size: illegal core_size_i is treated as W.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - core_stall_o = core_req_i (combinational).
  - On core_req_i=1: latch we, size, addr[1:0]; drive mem_req_o/we/be/addr/wd; clear counter; go to BUSY.
- BUSY:
  - core_stall_o=1; mem_req_o=1; counter increments each cycle.
  - mem_ready_i=1: if load, core_rd_o <= extended data; mem_req_o <= 0; go to DONE.
  - Timeout (MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT-1 without ready): core_rd_o <= 0; err_o pulses 1 cycle; mem_req_o <= 0; go to DONE.
  - If ready and timeout occur in the same cycle, ready wins and there is no err_o.
- DONE:
  - core_stall_o=0 so the core retires the instruction.
  - Unconditionally return to IDLE; core_req_i still high in DONE must not reissue.
- Latency: zero-wait memory (ready in the first BUSY cycle) gives 2 stall cycles.
- Byte enables (o = addr[1:0]):
  - B/BU: be = 0001<<o.
  - H/HU: be = 0011<<{o[1],0}.
  - W: be = 1111.
- Store data:
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd unchanged.
  - mem_wd_o is don't-care (driven 0) for loads.
- Load extraction (latched o):
  - B: sign-extend byte mem_rd_i[8*o+:8].
  - BU: zero-extend that byte.
  - H: sign-extend halfword mem_rd_i[16*o[1]+:16].
  - HU: zero-extend that halfword.
  - W: mem_rd_i unchanged.
  - core_rd_o holds its value until the next completed load or reset; stores leave it unchanged.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, is not issued.
  - IDLE goes straight to DONE: mem_req_o stays 0, err_o pulses 1 cycle, core_rd_o <= 0.
  - Stall lasts exactly 1 cycle.
- Not defined: misaligned accesses are issued with the low offset bits truncated:
  - H uses o[1] only.
  - W uses the aligned word.
  - err_o is driven only by timeout.

Test Plan:
- Store B, addr=0x0000_0103, wd=0x1234_56AB, ready in first BUSY cycle -> mem_be_o=1000, mem_wd_o=0xABAB_ABAB, mem_addr_o=0x100, stall high 2 cycles then low 1.
- Load B, addr=0x202, mem_rd_i=0x0080_0000 -> core_rd_o=0xFFFF_FF80; same access as BU -> 0x0000_0080.
- Load HU, addr=0x206, mem_rd_i=0xBEEF_1234 -> be=1100, core_rd_o=0x0000_BEEF; load W, addr=0x208, 3 wait cycles -> stall high 5 cycles, core_rd_o=mem_rd_i.
- MEM_TIMEOUT=4, mem_ready_i tied 0 -> mem_req_o high 4 cycles, err_o one pulse, core_rd_o=0, FSM returns to IDLE.
- rst_i asserted in the 2nd BUSY cycle -> next cycle mem_req_o=0, core_stall_o=core_req_i, err_o=0, core_rd_o=0.
- Load W at addr=0x102: with MISALIGN_TRAP_EN defined -> no mem_req_o, err_o pulse, 1 stall cycle; without it -> be=1111, mem_addr_o=0x100, normal completion.
